instr_fetch: RTL and testbench

Instruction fetch front end for the single-cycle/pipelined core. It owns the program counter and drives byte addresses into the combinational instruction ROM (`instructmem`). It captures each returned 32-bit word with its PC into a 2-entry skid buffer. Decode consumes entries through a valid/ready handshake. Branch redirects flush the buffer, and misaligned or out-of-bounds fetches raise a sticky fault.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_skid_buf.sv | 45 ++++
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: buffered entry layout,
// fetch FSM states and the instruction word size in bytes.
package fetch_pkg;

    localparam int FETCH_PC_W    = 64;
    localparam int FETCH_INSTR_W = 32;
    localparam int INSTR_BYTES   = 4;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]    pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of fetch entries; slot0 is always the head so the
// outputs come straight from a register.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    fetch_entry_t slot0, slot1;
    logic [1:0]   count;
    logic         pop_ok;
    logic [1:0]   wr_level;

    assign pop_ok   = pop && !empty;
    // slot the new entry lands in once this cycle's pop has shifted the head
    assign wr_level = count - {1'b0, pop_ok};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (pop_ok)                      slot0 <= slot1;
            if (push && wr_level == 2'd0)    slot0 <= din;
            if (push && wr_level == 2'd1)    slot1 <= din;
            count <= count + {1'b0, push} - {1'b0, pop_ok};
        end
    end

    assign head  = slot0;
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: owns the PC, checks fetch legality, pushes ROM words into
// the skid buffer and latches a sticky fault on an illegal fetch address.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = 64,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  MEM_SIZE    = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic [PC_WIDTH-1:0]    imem_address,
    input  logic [INSTR_WIDTH-1:0] imem_instruction,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instruction,
    output logic                   fault
);

    fetch_state_t        state, state_next;
    logic [PC_WIDTH-1:0] pc, pc_next;
    logic                pc_legal;
    logic                pop, push, flush;
    logic                buf_full, buf_empty;
    fetch_entry_t        wr_entry, head;

    assign imem_address = pc;

    // one extra bit so a PC near the top of the address space cannot wrap into range
    assign pc_legal = (pc[1:0] == 2'b00) &&
                      (({1'b0, pc} + (PC_WIDTH+1)'(INSTR_BYTES - 1)) < (PC_WIDTH+1)'(MEM_SIZE));

    assign pop = !buf_empty && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == RUN && !redirect_valid && !pc_legal)
            state_next = FAULT;
    end

    always_comb begin
        push    = 1'b0;
        flush   = 1'b0;
        pc_next = pc;
        if (state == RUN) begin
            if (redirect_valid) begin
                flush   = 1'b1;
                pc_next = redirect_target;
            end else if (pc_legal && (!buf_full || pop)) begin
                push    = 1'b1;
                pc_next = pc + PC_WIDTH'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc <= RESET_PC;
        else          pc <= pc_next;
    end

    assign wr_entry = '{pc: FETCH_PC_W'(pc), instr: FETCH_INSTR_W'(imem_instruction)};

    fetch_skid_buf u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .din     (wr_entry),
        .head    (head),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    assign out_valid       = !buf_empty;
    assign out_pc          = PC_WIDTH'(head.pc);
    assign out_instruction = INSTR_WIDTH'(head.instr);
    assign fault           = (state == FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random redirect/backpressure
// traffic compared cycle by cycle against a queue-based fetch model.
module tb_instr_fetch;

    localparam int          PCW = 64;
    localparam int          IW  = 32;
    localparam int          MEM = 1024;
    localparam logic [63:0] RPC = 64'h0;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [PCW-1:0]  imem_address;
    logic [IW-1:0]   imem_instruction;
    logic            redirect_valid = 1'b0;
    logic [PCW-1:0]  redirect_target = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [PCW-1:0]  out_pc;
    logic [IW-1:0]   out_instruction;
    logic            fault;

    always #5 clk = ~clk;

    logic [31:0] rom [MEM/4];

    always_comb begin
        imem_instruction = 32'hDEAD_BEEF;
        if (imem_address < 64'(MEM)) imem_instruction = rom[imem_address[9:2]];
    end

    instr_fetch #(
        .PC_WIDTH    (PCW),
        .INSTR_WIDTH (IW),
        .RESET_PC    (RPC),
        .MEM_SIZE    (MEM)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instruction  (out_instruction),
        .fault            (fault)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_pc;
    bit          m_fault;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [63:0] a);
        return (a % 4 == 0) && (a <= 64'(MEM - 4));
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ":valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({tag, ":fault"}, 64'(fault), 64'(m_fault));
        chk({tag, ":addr"}, imem_address, m_pc);
        if (q.size() > 0) begin
            chk({tag, ":pc"}, out_pc, q[0].pc);
            chk({tag, ":instr"}, 64'(out_instruction), 64'(q[0].instr));
        end
    endtask

    // One clock of the reference: handshake first, then redirect/fault/fetch rules.
    task automatic model_cycle(input bit rdr, input logic [63:0] tgt, input bit rdy);
        ent_t e;
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (!m_fault) begin
            if (rdr) begin
                q.delete();
                m_pc = tgt;
            end else if (!legal(m_pc)) begin
                m_fault = 1'b1;
            end else if (q.size() < 2) begin
                e.pc    = m_pc;
                e.instr = rom[m_pc[9:2]];
                q.push_back(e);
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic step(input bit rdr, input logic [63:0] tgt, input bit rdy, input string tag);
        redirect_valid  = rdr;
        redirect_target = tgt;
        out_ready       = rdy;
        check_outputs(tag);
        model_cycle(rdr, tgt, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        chk({tag, ":rst_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ":rst_fault"}, 64'(fault), 64'd0);
        chk({tag, ":rst_pc"}, out_pc, 64'd0);
        chk({tag, ":rst_instr"}, 64'(out_instruction), 64'd0);
        chk({tag, ":rst_addr"}, imem_address, RPC);
        q.delete();
        m_pc           = RPC;
        m_fault        = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [63:0] rand_target();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0)      return {32'($urandom), 32'($urandom)};
        else if (r == 1) return 64'($urandom_range(0, 255) * 4 + 2);
        else if (r == 2) return 64'(MEM - 4 - 4 * $urandom_range(0, 3));
        else if (r == 3) return 64'hFFFF_FFFF_FFFF_FFFC;
        else             return 64'($urandom_range(0, 255)) * 64'd4;
    endfunction

    initial begin
        for (int i = 0; i < MEM / 4; i++) rom[i] = $urandom;
        rom[0] = 32'hA0; rom[1] = 32'hA1; rom[2] = 32'hA2; rom[3] = 32'hA3;

        do_reset("init");
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, "straight");

        do_reset("bp_rst");
        step(1'b0, '0, 1'b1, "bp_first");
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, "bp_hold");
        chk("bp_stall_addr", imem_address, 64'd8);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, "bp_drain");

        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, "pre_flush");
        step(1'b1, 64'h40, 1'b0, "flush");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, "post_flush");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "flush_drain");

        step(1'b1, 64'h42, 1'b1, "misalign");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "mis_wait");
        step(1'b1, 64'h80, 1'b1, "mis_ignored");
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, "mis_hold");
        chk("mis_sticky", 64'(fault), 64'd1);

        do_reset("eom_rst");
        step(1'b1, 64'h3F8, 1'b0, "eom");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, "eom_bp");
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, "eom_drain");

        do_reset("mid_rst0");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, "mid_fill");
        do_reset("mid_rst");
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, "restart");

        for (int seg = 0; seg < 8; seg++) begin
            do_reset("rnd_rst");
            for (int c = 0; c < 150; c++) begin
                bit          rdr;
                bit          rdy;
                logic [63:0] tgt;
                rdr = ($urandom_range(0, 11) == 0);
                rdy = ($urandom_range(0, 3) != 0);
                tgt = rand_target();
                step(rdr, tgt, rdy, "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
